// File: rtl/cola_botones_if.sv
// Button event queue bus: button pulses and consumer handshake in, queued events and loss status out.
// The bench drives through the master modport; the queue itself uses the slave modport.
interface cola_botones_if #(
    parameter int NUM_BTN = 4,
    parameter int DEPTH   = 4
);
    logic [NUM_BTN-1:0]         btn_pulse;
    logic                       evt_ready;
    logic                       evt_valid;
    logic [$clog2(NUM_BTN)-1:0] evt_code;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic [7:0]                 drop_cnt;
    logic                       overflow;

    modport master (
        output btn_pulse, evt_ready,
        input  evt_valid, evt_code, fifo_count, drop_cnt, overflow
    );

    modport slave (
        input  btn_pulse, evt_ready,
        output evt_valid, evt_code, fifo_count, drop_cnt, overflow
    );
endinterface

// File: rtl/cola_botones.sv
// Turns rising edges on button pulse lines into queued button-index events.
// One pending flag per button feeds a small FIFO; lost events are counted and flagged.
module cola_botones #(
    parameter int NUM_BTN = 4,
    parameter int DEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    cola_botones_if.slave bus
);
    localparam int IW = $clog2(NUM_BTN);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [NUM_BTN-1:0] btn_prev;
    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] push_mask;
    logic [NUM_BTN-1:0] lost;
    logic [NUM_BTN-1:0] pend_next;
    logic [IW-1:0]      push_idx;
    logic               do_push;
    logic               do_pop;

    logic [IW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [7:0]         drop;
    logic               ovf;

    always_comb begin
        rise     = bus.btn_pulse & ~btn_prev;
        push_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[i]) push_idx = IW'(i);
        end
        // Eligibility uses the pre-pop count, so a full queue never pushes in a pop cycle.
        do_push   = (pend != '0) && (count < FULL_CNT);
        push_mask = do_push ? (NUM_BTN'(1) << push_idx) : '0;
        do_pop    = (count != '0) && bus.evt_ready;
        lost      = rise & pend & ~push_mask;
        pend_next = (pend & ~push_mask) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev <= '0;
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop     <= '0;
            ovf      <= 1'b0;
        end else begin
            btn_prev <= bus.btn_pulse;
            pend     <= pend_next;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
            if (lost != '0) begin
                ovf <= 1'b1;
                if (drop != 8'hFF) drop <= drop + 8'd1;
            end
        end
    end

    // Storage needs no reset: the head is only exposed while count is nonzero.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_idx;
    end

    assign bus.evt_valid  = (count != '0);
    assign bus.evt_code   = bus.evt_valid ? mem[rd_ptr] : '0;
    assign bus.fifo_count = count;
    assign bus.drop_cnt   = drop;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_cola_botones.sv
// Self-checking bench for cola_botones: directed vector table, corner-case sequences,
// and random traffic against a queue-based reference model.
module tb_cola_botones;
    localparam int NB = 4;
    localparam int DP = 4;

    logic clk;
    logic reset;

    cola_botones_if #(.NUM_BTN(NB), .DEPTH(DP)) bus ();

    cola_botones #(.NUM_BTN(NB), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_prev [NB];
    bit m_pend [NB];
    int m_q [$];
    int m_drop;
    bit m_ovf;

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       rst;
        logic       valid;
        int         code;
        int         count;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] b, input logic r, input logic rs);
        int  sz;
        int  pushed;
        bit  any_lost;
        bit  rise [NB];
        if (rs) begin
            m_q.delete();
            for (int i = 0; i < NB; i++) begin
                m_prev[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_drop = 0;
            m_ovf  = 1'b0;
            return;
        end
        sz     = m_q.size();
        pushed = -1;
        for (int i = 0; i < NB; i++) rise[i] = b[i] && !m_prev[i];
        if (sz < DP) begin
            for (int i = 0; i < NB; i++) begin
                if (m_pend[i]) begin
                    pushed = i;
                    break;
                end
            end
        end
        if (sz > 0 && r) void'(m_q.pop_front());
        if (pushed >= 0) begin
            m_q.push_back(pushed);
            m_pend[pushed] = 1'b0;
        end
        any_lost = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (rise[i]) begin
                if (m_pend[i]) any_lost = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        if (any_lost) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        for (int i = 0; i < NB; i++) m_prev[i] = b[i];
    endtask

    task automatic compare_model();
        chk("valid", int'(bus.evt_valid), (m_q.size() != 0) ? 1 : 0);
        chk("code", int'(bus.evt_code), (m_q.size() != 0) ? m_q[0] : 0);
        chk("count", int'(bus.fifo_count), m_q.size());
        chk("drop", int'(bus.drop_cnt), m_drop);
        chk("ovf", int'(bus.overflow), int'(m_ovf));
    endtask

    task automatic step(input logic [3:0] b, input logic r, input logic rs);
        bus.btn_pulse = b;
        bus.evt_ready = r;
        reset         = rs;
        @(posedge clk);
        model_step(b, r, rs);
        #1;
        compare_model();
    endtask

    initial begin
        bus.btn_pulse = '0;
        bus.evt_ready = 1'b0;
        reset         = 1'b1;
        m_drop        = 0;
        m_ovf         = 1'b0;

        //            btn      rdy   rst   valid code count
        tbl[0]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 2, 1};
        tbl[3]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 2, 1};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2, 1};
        tbl[5]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[6]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2, 1};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[8]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[9]  = '{4'b1011, 1'b1, 1'b0, 1'b1, 0, 1};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1, 1};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b1, 3, 1};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].btn, tbl[i].ready, tbl[i].rst);
            chk($sformatf("tbl%0d_valid", i), int'(bus.evt_valid), int'(tbl[i].valid));
            chk($sformatf("tbl%0d_code", i), int'(bus.evt_code), tbl[i].code);
            chk($sformatf("tbl%0d_count", i), int'(bus.fifo_count), tbl[i].count);
        end
        chk("tbl_drop", int'(bus.drop_cnt), 0);

        // Full queue, pending button, then a lost re-press
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0);
        chk("full_count", int'(bus.fifo_count), 4);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk("lost_count", int'(bus.fifo_count), 4);
        chk("lost_drop", int'(bus.drop_cnt), 1);
        chk("lost_ovf", int'(bus.overflow), 1);
        step(4'b0000, 1'b1, 1'b0);
        chk("pop_full_count", int'(bus.fifo_count), 3);
        chk("pop_full_head", int'(bus.evt_code), 1);
        step(4'b0000, 1'b0, 1'b0);
        chk("refill_count", int'(bus.fifo_count), 4);

        // Saturation: keep btn 1 pending against a full queue
        step(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            step(4'b0010, 1'b0, 1'b0);
        end
        chk("sat_drop", int'(bus.drop_cnt), 255);
        chk("sat_ovf", int'(bus.overflow), 1);

        // Reset mid-operation with three queued and button 2 pending
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1011, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        chk("pre_rst_count", int'(bus.fifo_count), 3);
        step(4'b0000, 1'b0, 1'b1);
        chk("rst_valid", int'(bus.evt_valid), 0);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_drop", int'(bus.drop_cnt), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);
        chk("no_stale_valid", int'(bus.evt_valid), 0);

        // Button high through reset release counts as an edge
        step(4'b0001, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0);
        chk("hold_rel_count0", int'(bus.fifo_count), 0);
        step(4'b0001, 1'b0, 1'b0);
        chk("hold_rel_count1", int'(bus.fifo_count), 1);
        chk("hold_rel_code", int'(bus.evt_code), 0);

        // Random traffic: alternate draining and starving phases
        begin
            logic [3:0] b;
            logic       r;
            logic       rs;
            b = 4'b0000;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
                if (((n / 500) % 2) == 0) r = ($urandom_range(0, 3) != 0);
                else                      r = ($urandom_range(0, 7) == 0);
                rs = ($urandom_range(0, 299) == 0);
                step(b, r, rs);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cola_botones.md
COLA_BOTONES -- requirements
Module: cola_botones

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4, number of button pulse inputs (2..8).
REQ-002 SHALL have parameter DEPTH, default 4, event FIFO depth (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_pulse  input  NUM_BTN  per-button output pulses of the Boton stages; each pulse may last several cycles.
REQ-006 SHALL have port evt_ready  input  1  consumer ready to accept the head event.
REQ-007 SHALL have port evt_valid  output  1  head event available.
REQ-008 SHALL have port evt_code  output  clog2(NUM_BTN)  index of the button for the head event.
REQ-009 SHALL have port fifo_count  output  clog2(DEPTH)+1  number of queued events.
REQ-010 SHALL have port drop_cnt  output  8  count of lost events, saturating.
REQ-011 SHALL have port overflow  output  1  sticky flag, set when any event is lost.

Function
REQ-012 SHALL register btn_pulse into btn_prev every cycle, and SHALL detect an event for button i only on a rising edge: btn_pulse[i]=1 and btn_prev[i]=0.
REQ-013 SHALL set pend[i] on the clock edge at which an event for button i is detected.
REQ-014 SHALL, in each cycle where pend!=0 and fifo_count<DEPTH, push the lowest-indexed pending button into the FIFO and clear that pend bit, with one push per cycle maximum.
REQ-015 SHALL keep pend[i] set when a new event for i is detected in the same cycle its pend bit is pushed.
REQ-016 SHALL treat a new event for button i as lost when pend[i] is already 1 and is not being pushed that cycle.
REQ-017 SHALL, on each lost event, increment drop_cnt saturating at 255 and set overflow; overflow clears only on reset.
REQ-018 SHALL count multiple events lost in the same cycle as a single increment of drop_cnt.
REQ-019 SHALL produce latency as follows: rising edge sampled at clock k sets pend after edge k; push occurs at edge k+1; evt_valid=1 after edge k+1 when the FIFO was empty. There SHALL be no bypass path.
REQ-020 SHALL drive evt_valid = (fifo_count!=0) and evt_code = the FIFO head entry.
REQ-021 SHALL pop the head on a clock edge where evt_valid=1 and evt_ready=1.
REQ-022 SHALL hold evt_code stable while evt_valid=1 and evt_ready=0.
REQ-023 SHALL decide push eligibility from fifo_count before any pop in the same cycle; when full, a simultaneous pop SHALL NOT enable a push that cycle.
REQ-024 SHALL, on simultaneous push and pop with a non-full FIFO, leave fifo_count unchanged and move both pointers.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL ignore evt_ready when the FIFO is empty; no pop occurs and fifo_count does not underflow.
REQ-027 SHALL NOT alter queued or pending events through btn_pulse levels held high; only a new rising edge creates an event.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, clear btn_prev, pend, both pointers, fifo_count, drop_cnt and overflow, and drive evt_valid=0, evt_code=0.
REQ-029 SHALL make reset take priority over any simultaneous event, push or pop; queued and pending events SHALL be discarded on mid-operation reset.
REQ-030 SHALL treat a btn_pulse bit that is high at the first edge after reset release as a rising edge, generating an event.

Verification
REQ-031 Single event: pulse btn_pulse[2] high for 10 cycles, evt_ready=0 -> evt_valid=1 two edges after the rise, evt_code=2, fifo_count=1, exactly one event.
REQ-032 Simultaneous pulses: btn_pulse=4'b1011 rising in one cycle, evt_ready=1 -> codes popped in order 0, 1, 3 on consecutive cycles; drop_cnt=0.
REQ-033 Full FIFO (DEPTH=4): enqueue 4 events with evt_ready=0, then raise btn 1 once (pending) and again after a fall -> fifo_count=4, drop_cnt=1, overflow=1; after one pop, btn 1 enters the queue on the next edge.
REQ-034 Full with pop: fifo_count=4, pend!=0, evt_ready=1 for one cycle -> fifo_count=3 after that edge and 4 after the following edge.
REQ-035 Saturation: generate 300 lost events -> drop_cnt=255, overflow=1.
REQ-036 Reset mid-operation: fifo_count=3, pend=4'b0100, assert reset for one cycle -> all outputs 0 on the next edge; no stale events afterwards.
